// File: rtl/weight_column_loader.sv
// weight_column_loader
//   North-edge weight transmitter for one systolic-array column. Collects ROWS
//   signed weights from a valid/ready stream, shifts them down the column's
//   weight/accept chain so row r ends with W[r] in its shadow register, then
//   pulses every row's switch line to make the shadow weights active.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   w_data         signed weight, k-th accepted word is W[k]
//   w_valid        w_data valid
//   w_ready        loader can accept w_data (IDLE / COLLECT)
//   swap_req       request switch pulse, honoured only in LOADED
//   col_weight_out weight driven into the top PE
//   col_accept_w   per-row weight-accept enable (bit r -> row r)
//   row_switch     per-row shadow-to-active switch (bit r -> row r)
//   busy           COLLECT, SHIFT or SWITCH
//   loaded         shadow weights valid and not yet switched
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for the first word of a new column load
// COLLECT | buffering words 1..ROWS-1, stalls on w_valid gaps
// SHIFT   | ROWS cycles driving buf[ROWS-1-k] down the chain
// LOADED  | shadow weights valid, waiting for swap_req
// SWITCH  | one-cycle row_switch pulse on all rows

module weight_column_loader #(
   parameter int ROWS       = 4,
   parameter int DATA_WIDTH = 16,
   parameter int AUTO_SWAP  = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] w_data,
   input  logic                         w_valid,
   output logic                         w_ready,
   input  logic                         swap_req,
   output logic signed [DATA_WIDTH-1:0] col_weight_out,
   output logic [ROWS-1:0]              col_accept_w,
   output logic [ROWS-1:0]              row_switch,
   output logic                         busy,
   output logic                         loaded
);

   localparam int            CW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_SHIFT,
      S_LOADED,
      S_SWITCH
   } state_t;

   state_t                       state;
   logic [CW-1:0]                idx;
   logic [CW-1:0]                shift_left;
   logic signed [DATA_WIDTH-1:0] wbuf [ROWS];
   logic                         xfer;

   assign xfer = w_valid && w_ready;

   // Shift timer counts down; shift_left = ROWS-1-k. Row r accepts once k >= r,
   // i.e. while shift_left <= ROWS-1-r.
   function automatic logic [ROWS-1:0] accept_mask(input logic [CW-1:0] left);
      logic [ROWS-1:0] m;
      m = '0;
      for (int r = 0; r < ROWS; r++) begin
         m[r] = (int'(left) <= (ROWS - 1 - r));
      end
      return m;
   endfunction

   // Buffer contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (xfer) begin
         wbuf[idx] <= w_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         idx            <= '0;
         shift_left     <= '0;
         w_ready        <= 1'b0;
         col_weight_out <= '0;
         col_accept_w   <= '0;
         row_switch     <= '0;
         busy           <= 1'b0;
         loaded         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               w_ready <= 1'b1;
               if (xfer) begin
                  busy <= 1'b1;
                  if (ROWS == 1) begin
                     // The single word is also the last one: SHIFT k=0 drives it directly.
                     state          <= S_SHIFT;
                     idx            <= '0;
                     w_ready        <= 1'b0;
                     shift_left     <= LAST;
                     col_weight_out <= w_data;
                     col_accept_w   <= accept_mask(LAST);
                  end else begin
                     state <= S_COLLECT;
                     idx   <= idx + 1'b1;
                  end
               end
            end
            S_COLLECT: begin
               if (xfer) begin
                  if (idx == LAST) begin
                     // buf[ROWS-1] is being written now, so forward w_data for k=0.
                     state          <= S_SHIFT;
                     idx            <= '0;
                     w_ready        <= 1'b0;
                     shift_left     <= LAST;
                     col_weight_out <= w_data;
                     col_accept_w   <= accept_mask(LAST);
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               if (shift_left == '0) begin
                  col_weight_out <= '0;
                  col_accept_w   <= '0;
                  if (AUTO_SWAP != 0) begin
                     state      <= S_SWITCH;
                     row_switch <= '1;
                  end else begin
                     state  <= S_LOADED;
                     busy   <= 1'b0;
                     loaded <= 1'b1;
                  end
               end else begin
                  shift_left     <= shift_left - 1'b1;
                  col_weight_out <= wbuf[shift_left - 1'b1];
                  col_accept_w   <= accept_mask(shift_left - 1'b1);
               end
            end
            S_LOADED: begin
               if (swap_req) begin
                  state      <= S_SWITCH;
                  loaded     <= 1'b0;
                  busy       <= 1'b1;
                  row_switch <= '1;
               end
            end
            S_SWITCH: begin
               state      <= S_IDLE;
               row_switch <= '0;
               busy       <= 1'b0;
               w_ready    <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_column_loader.sv
module tb_weight_column_loader;

   logic               clk = 1'b0;
   logic               rst, a_rst;
   logic signed [15:0] w_data, a_w_data;
   logic               w_valid, a_w_valid;
   logic               swap_req, a_swap_req;
   logic               w_ready, a_w_ready;
   logic signed [15:0] col_weight_out, a_col_weight_out;
   logic [3:0]         col_accept_w, a_col_accept_w;
   logic [3:0]         row_switch, a_row_switch;
   logic               busy, a_busy;
   logic               loaded, a_loaded;

   int vectors = 0;
   int miscompares = 0;

   logic signed [15:0] wv      [4] = '{16'sh0100, 16'sh0200, 16'sh0300, 16'sh0400};
   logic signed [15:0] exp_out [4] = '{16'sh0400, 16'sh0300, 16'sh0200, 16'sh0100};
   logic [3:0]         exp_acc [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
   logic signed [15:0] aw      [4] = '{16'sh0011, 16'sh0022, 16'sh0033, 16'sh0044};
   logic signed [15:0] a_exp   [4] = '{16'sh0044, 16'sh0033, 16'sh0022, 16'sh0011};

   always #5 clk = ~clk;

   weight_column_loader #(.ROWS(4), .DATA_WIDTH(16), .AUTO_SWAP(0)) dut (
      .clk(clk), .rst(rst), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
      .swap_req(swap_req), .col_weight_out(col_weight_out), .col_accept_w(col_accept_w),
      .row_switch(row_switch), .busy(busy), .loaded(loaded)
   );

   weight_column_loader #(.ROWS(4), .DATA_WIDTH(16), .AUTO_SWAP(1)) dut_auto (
      .clk(clk), .rst(a_rst), .w_data(a_w_data), .w_valid(a_w_valid), .w_ready(a_w_ready),
      .swap_req(a_swap_req), .col_weight_out(a_col_weight_out), .col_accept_w(a_col_accept_w),
      .row_switch(a_row_switch), .busy(a_busy), .loaded(a_loaded)
   );

   // Behavioural 4-PE column: each PE forwards its registered weight while its
   // accept is high, 0 otherwise; row_switch copies shadow into active.
   logic signed [15:0] shadow [4];
   logic signed [15:0] active [4];

   always @(posedge clk) begin
      if (col_accept_w[0]) shadow[0] <= col_weight_out;
      for (int r = 1; r < 4; r++) begin
         if (col_accept_w[r]) shadow[r] <= col_accept_w[r-1] ? shadow[r-1] : 16'sh0000;
      end
      for (int r = 0; r < 4; r++) begin
         if (row_switch[r]) active[r] <= shadow[r];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic stream4(input logic signed [15:0] v0, v1, v2, v3);
      logic signed [15:0] v [4];
      v = '{v0, v1, v2, v3};
      for (int i = 0; i < 4; i++) begin
         w_valid = 1'b1;
         w_data  = v[i];
         step();
      end
      w_valid = 1'b0;
      w_data  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; a_rst = 1'b1;
      w_valid = 1'b0; w_data = '0; swap_req = 1'b0;
      a_w_valid = 1'b0; a_w_data = '0; a_swap_req = 1'b0;
      step(); step();
      vectors++;
      if ({w_ready, busy, loaded, col_weight_out, col_accept_w, row_switch} !== 27'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy=%b busy=%b ld=%b w=%h acc=%b sw=%b, want all 0",
                  w_ready, busy, loaded, col_weight_out, col_accept_w, row_switch);
      end
      vectors++;
      if ({a_w_ready, a_busy, a_loaded, a_col_weight_out, a_col_accept_w, a_row_switch} !== 27'd0) begin
         miscompares++;
         $display("FAIL reset_outputs_auto: got rdy=%b busy=%b ld=%b, want 0", a_w_ready, a_busy, a_loaded);
      end
      rst = 1'b0; a_rst = 1'b0;
      step();
      vectors++;
      if (w_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_ready: got rdy=%b busy=%b, want rdy=1 busy=0", w_ready, busy);
      end
   endtask

   task automatic test_back_to_back();
      stream4(wv[0], wv[1], wv[2], wv[3]);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (col_weight_out !== exp_out[k] || col_accept_w !== exp_acc[k] || busy !== 1'b1 || w_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_shift k=%0d: got w=%h acc=%b busy=%b rdy=%b, want w=%h acc=%b busy=1 rdy=0",
                     k, col_weight_out, col_accept_w, busy, w_ready, exp_out[k], exp_acc[k]);
         end
         step();
      end
      vectors++;
      if (loaded !== 1'b1 || busy !== 1'b0 || col_accept_w !== 4'b0 || col_weight_out !== 16'sh0 || w_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_loaded: got ld=%b busy=%b acc=%b w=%h rdy=%b, want ld=1 busy=0 acc=0 w=0 rdy=0",
                  loaded, busy, col_accept_w, col_weight_out, w_ready);
      end
      for (int r = 0; r < 4; r++) begin
         vectors++;
         if (shadow[r] !== wv[r]) begin
            miscompares++;
            $display("FAIL b2b_shadow row %0d: got %h, want %h", r, shadow[r], wv[r]);
         end
      end
   endtask

   task automatic test_swap();
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (loaded !== 1'b1 || row_switch !== 4'h0) begin
            miscompares++;
            $display("FAIL swap_hold: got ld=%b sw=%b, want ld=1 sw=0000", loaded, row_switch);
         end
         step();
      end
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      vectors++;
      if (row_switch !== 4'hF || busy !== 1'b1 || loaded !== 1'b0 || w_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL swap_pulse: got sw=%b busy=%b ld=%b rdy=%b, want sw=1111 busy=1 ld=0 rdy=0",
                  row_switch, busy, loaded, w_ready);
      end
      step();
      vectors++;
      if (row_switch !== 4'h0 || w_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL swap_idle: got sw=%b rdy=%b busy=%b, want sw=0000 rdy=1 busy=0", row_switch, w_ready, busy);
      end
      for (int r = 0; r < 4; r++) begin
         vectors++;
         if (active[r] !== wv[r]) begin
            miscompares++;
            $display("FAIL swap_active row %0d: got %h, want %h", r, active[r], wv[r]);
         end
      end
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 4; i++) begin
         w_valid = 1'b1;
         w_data  = wv[i];
         step();
         w_valid = 1'b0;
         w_data  = 16'sh7777;
         if (i < 3) begin
            for (int g = 0; g < 3; g++) begin
               vectors++;
               if (w_ready !== 1'b1 || col_accept_w !== 4'b0 || busy !== 1'b1) begin
                  miscompares++;
                  $display("FAIL gap_stall word %0d gap %0d: got rdy=%b acc=%b busy=%b, want rdy=1 acc=0000 busy=1",
                           i, g, w_ready, col_accept_w, busy);
               end
               step();
            end
         end
      end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (col_weight_out !== exp_out[k] || col_accept_w !== exp_acc[k]) begin
            miscompares++;
            $display("FAIL gap_shift k=%0d: got w=%h acc=%b, want w=%h acc=%b",
                     k, col_weight_out, col_accept_w, exp_out[k], exp_acc[k]);
         end
         step();
      end
      for (int r = 0; r < 4; r++) begin
         vectors++;
         if (shadow[r] !== wv[r]) begin
            miscompares++;
            $display("FAIL gap_shadow row %0d: got %h, want %h", r, shadow[r], wv[r]);
         end
      end
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      step();
      vectors++;
      if (w_ready !== 1'b1 || loaded !== 1'b0) begin
         miscompares++;
         $display("FAIL gap_return_idle: got rdy=%b ld=%b, want rdy=1 ld=0", w_ready, loaded);
      end
   endtask

   task automatic test_early_swap();
      swap_req = 1'b1;
      stream4(16'sh0A0A, 16'sh0B0B, 16'sh0C0C, 16'sh0D0D);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (row_switch !== 4'h0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL early_swap_shift k=%0d: got sw=%b busy=%b, want sw=0000 busy=1", k, row_switch, busy);
         end
         if (k == 3) swap_req = 1'b0;
         step();
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (row_switch !== 4'h0 || loaded !== 1'b1) begin
            miscompares++;
            $display("FAIL early_swap_loaded cycle %0d: got sw=%b ld=%b, want sw=0000 ld=1", i, row_switch, loaded);
         end
         step();
      end
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      step();
      vectors++;
      if (w_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL early_swap_exit: got rdy=%b, want 1", w_ready);
      end
   endtask

   task automatic test_reset_mid_shift();
      stream4(wv[0], wv[1], wv[2], wv[3]);
      step(); step();
      vectors++;
      if (col_weight_out !== 16'sh0200 || col_accept_w !== 4'b0111) begin
         miscompares++;
         $display("FAIL rst_mid_k2: got w=%h acc=%b, want w=0200 acc=0111", col_weight_out, col_accept_w);
      end
      rst = 1'b1;
      step();
      vectors++;
      if ({w_ready, busy, loaded, col_weight_out, col_accept_w, row_switch} !== 27'd0) begin
         miscompares++;
         $display("FAIL rst_mid_outputs: got rdy=%b busy=%b ld=%b w=%h acc=%b sw=%b, want all 0",
                  w_ready, busy, loaded, col_weight_out, col_accept_w, row_switch);
      end
      rst = 1'b0;
      step();
      vectors++;
      if (w_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_idle: got rdy=%b busy=%b, want rdy=1 busy=0", w_ready, busy);
      end
      stream4(16'shFF00, 16'shFF00, 16'shFF00, 16'shFF00);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (col_weight_out !== 16'shFF00 || col_accept_w !== exp_acc[k]) begin
            miscompares++;
            $display("FAIL neg_shift k=%0d: got w=%h acc=%b, want w=ff00 acc=%b", k, col_weight_out, col_accept_w, exp_acc[k]);
         end
         step();
      end
      vectors++;
      if (loaded !== 1'b1) begin
         miscompares++;
         $display("FAIL neg_loaded: got ld=%b, want 1", loaded);
      end
      for (int r = 0; r < 4; r++) begin
         vectors++;
         if (shadow[r] !== 16'shFF00) begin
            miscompares++;
            $display("FAIL neg_shadow row %0d: got %h, want ff00", r, shadow[r]);
         end
      end
   endtask

   task automatic test_auto_swap();
      for (int i = 0; i < 4; i++) begin
         a_w_valid = 1'b1;
         a_w_data  = aw[i];
         step();
      end
      a_w_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (a_col_weight_out !== a_exp[k] || a_col_accept_w !== exp_acc[k] || a_loaded !== 1'b0) begin
            miscompares++;
            $display("FAIL auto_shift k=%0d: got w=%h acc=%b ld=%b, want w=%h acc=%b ld=0",
                     k, a_col_weight_out, a_col_accept_w, a_loaded, a_exp[k], exp_acc[k]);
         end
         step();
      end
      vectors++;
      if (a_row_switch !== 4'hF || a_busy !== 1'b1 || a_loaded !== 1'b0 || a_col_accept_w !== 4'b0) begin
         miscompares++;
         $display("FAIL auto_switch: got sw=%b busy=%b ld=%b acc=%b, want sw=1111 busy=1 ld=0 acc=0000",
                  a_row_switch, a_busy, a_loaded, a_col_accept_w);
      end
      step();
      vectors++;
      if (a_row_switch !== 4'h0 || a_w_ready !== 1'b1 || a_loaded !== 1'b0 || a_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL auto_idle: got sw=%b rdy=%b ld=%b busy=%b, want sw=0000 rdy=1 ld=0 busy=0",
                  a_row_switch, a_w_ready, a_loaded, a_busy);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_swap();
      test_gaps();
      test_early_swap();
      test_reset_mid_shift();
      test_auto_swap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
